// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid pipeline stage with registered in_ready
// Optional downstream-stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid #(
    parameter int DATA_W = 137,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              issue;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign occ       = state;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && issue) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (issue) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists
                if (issue) begin
                    state_nxt      = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state    <= state_nxt;
            // registered copy of "next state is not FULL" keeps out_ready off the in_ready path
            in_ready <= (state_nxt != FULL);
            if (load_main) begin
                main_data <= in_data;
            end else if (main_from_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DATA_W = 137;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  model_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 1'b0;
    logic [DATA_W-1:0] sb_q[$];

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occ      (occ)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after posedge; everything is sampled at negedge.
    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                         input logic fl, input logic rs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W; i += 32) begin
            v = {v[DATA_W-33:0], 32'($urandom)};
        end
        return v;
    endfunction

    always @(negedge clk) begin
        int sz;
        sz = sb_q.size();
        if (armed) begin
            check("occ", DATA_W'(occ), DATA_W'(sz));
            check("out_valid", DATA_W'(out_valid), DATA_W'(sz != 0));
            check("in_ready", DATA_W'(in_ready), DATA_W'(sz != 2));
            if (sz != 0) begin
                check("out_data", out_data, sb_q[0]);
            end
`ifdef PIPE_STALL_CNT_EN
            check("stall_cnt", DATA_W'(stall_cnt), DATA_W'(model_cnt));
`endif
        end
        if (rst) begin
            sb_q.delete();
            armed = 1'b1;
`ifdef PIPE_STALL_CNT_EN
            model_cnt = '0;
`endif
        end else begin
`ifdef PIPE_STALL_CNT_EN
            if (sz != 0 && !out_ready && model_cnt != {CNT_W{1'b1}}) begin
                model_cnt = model_cnt + 1'b1;
            end
`endif
            if (flush) begin
                sb_q.delete();
            end else begin
                if (sz != 0 && out_ready) begin
                    void'(sb_q.pop_front());
                end
                if (in_valid && sz != 2) begin
                    sb_q.push_back(in_data);
                end
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 1, 0, 0);
        check("rst_occ", DATA_W'(occ), '0);
        check("rst_out_valid", DATA_W'(out_valid), '0);
        check("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
        check("rst_out_data", out_data, '0);

        for (int i = 1; i <= 4; i++) begin
            drive(1, DATA_W'(i), 1, 0, 0);
        end
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        drive(1, DATA_W'('hA), 0, 0, 0);
        drive(1, DATA_W'('hB), 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        check("full_occ", DATA_W'(occ), DATA_W'(2));
        check("full_in_ready", DATA_W'(in_ready), '0);
        check("full_out_data", out_data, DATA_W'('hA));
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        drive(1, DATA_W'('hA), 0, 0, 0);
        drive(1, DATA_W'('hB), 0, 0, 0);
        drive(1, DATA_W'('hC), 0, 1, 0);
        check("flush_occ", DATA_W'(occ), '0);
        check("flush_out_valid", DATA_W'(out_valid), '0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        drive(1, DATA_W'('h5), 1, 0, 1);
        check("rst_accept_occ", DATA_W'(occ), '0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        drive(1, DATA_W'('h7), 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 0, 0, 0);
        end
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_data(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0));
        end
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
